// File: rtl/dot_product_acc_seq.sv
// rtl/dot_product_acc_seq.sv - sequential 4-element dot-product accumulator with valid/ready handshake
// Adds one captured product per clock into a 2N+2-bit accumulator, then holds the sum until accepted.
module dot_product_acc_seq #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     products [0:3],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N+1:0]     sum,
  output logic               pulse_acc,
  output logic [3:0]         cycle_count_acc
);

  localparam int PW = 2 * N;
  localparam int SW = 2 * N + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] cap_q [0:3];
  logic [PW-1:0] cap_d [0:3];
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          pulse_acc_q, pulse_acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] acc_next;

  assign acc_next = acc_q + {2'b00, cap_q[idx_q]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < 4; i++) begin
      cap_d[i] = cap_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < 4; i++) begin
            cap_d[i] = products[i];
          end
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_next;
        idx_d = idx_q + 2'd1;
        cnt_d = cnt_q + 4'd1;
        // The last element goes straight into sum so out_valid lines up with the final add.
        if (idx_q == 2'd3) begin
          sum_d       = acc_next;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Registered copies of the next state keep every flag output glitch-free.
    in_ready_d  = (state_d == S_IDLE);
    pulse_acc_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      pulse_acc_q <= 1'b0;
      cnt_q       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      pulse_acc_q <= pulse_acc_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign sum             = sum_q;
  assign pulse_acc       = pulse_acc_q;
  assign cycle_count_acc = cnt_q;

endmodule

// File: tb/tb_dot_product_acc_seq.sv
// tb/tb_dot_product_acc_seq.sv - directed self-checking bench for dot_product_acc_seq
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_dot_product_acc_seq;

  localparam int N = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  products [0:3];
  logic            out_valid;
  logic            out_ready;
  logic [2*N+1:0]  sum;
  logic            pulse_acc;
  logic [3:0]      cycle_count_acc;

  int checks;
  int errors;

  dot_product_acc_seq #(.N(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .products        (products),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sum             (sum),
    .pulse_acc       (pulse_acc),
    .cycle_count_acc (cycle_count_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_products(input logic [15:0] a, b, c, d);
    products[0] = a;
    products[1] = b;
    products[2] = c;
    products[3] = d;
  endtask

  // One full transaction starting on a falling edge with the DUT idle.
  // noisy: scribble on the inputs during ACC; hold: cycles of out_ready=0 in DONE.
  task automatic do_txn(input string tag, input logic [15:0] a, b, c, d,
                        input logic [31:0] exp_sum, input logic [3:0] exp_cnt,
                        input bit noisy, input int hold);
    set_products(a, b, c, d);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({tag, ".ready_pre"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = noisy;
    if (noisy) set_products(16'd100, 16'd100, 16'd100, 16'd100);
    check({tag, ".ready_e0"}, in_ready, 0);
    check({tag, ".pulse_e0"}, pulse_acc, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (noisy) in_valid = ~in_valid;
      check({tag, ".pulse_acc"}, pulse_acc, 1);
      check({tag, ".valid_acc"}, out_valid, 0);
      check({tag, ".ready_acc"}, in_ready, 0);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".valid_e4"}, out_valid, 1);
    check({tag, ".pulse_e4"}, pulse_acc, 0);
    check({tag, ".ready_e4"}, in_ready, 0);
    check({tag, ".sum"}, sum, exp_sum);
    check({tag, ".cnt"}, cycle_count_acc, exp_cnt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".bp_valid"}, out_valid, 1);
      check({tag, ".bp_sum"}, sum, exp_sum);
      check({tag, ".bp_cnt"}, cycle_count_acc, exp_cnt);
      check({tag, ".bp_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid_post"}, out_valid, 0);
    check({tag, ".ready_post"}, in_ready, 1);
    check({tag, ".sum_hold"}, sum, exp_sum);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_products(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.sum", sum, 0);
    check("rst.pulse", pulse_acc, 0);
    check("rst.cnt", cycle_count_acc, 0);
    rst = 1'b0;
    @(negedge clk);

    do_txn("basic", 16'd1, 16'd2, 16'd3, 16'd4, 32'd10, 4'd4, 1'b0, 0);
    do_txn("max", 16'd65025, 16'd65025, 16'd65025, 16'd65025, 32'h3F804, 4'd8, 1'b0, 0);
    do_txn("bp", 16'd3, 16'd4, 16'd5, 16'd6, 32'd18, 4'd12, 1'b0, 3);
    do_txn("iso", 16'd5, 16'd6, 16'd7, 16'd8, 32'd26, 4'd0, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("iso.no_second_pulse", pulse_acc, 0);
      check("iso.no_second_cnt", cycle_count_acc, 0);
    end

    // Reset lands between E2 and E3 of an in-flight transaction.
    set_products(16'd9, 16'd9, 16'd9, 16'd9);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst.in_ready", in_ready, 1);
    check("mid_rst.out_valid", out_valid, 0);
    check("mid_rst.sum", sum, 0);
    check("mid_rst.pulse", pulse_acc, 0);
    check("mid_rst.cnt", cycle_count_acc, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst.never_valid", out_valid, 0);
      check("mid_rst.idle_pulse", pulse_acc, 0);
    end

    do_txn("wrap0", 16'd2, 16'd2, 16'd2, 16'd2, 32'd8, 4'd4, 1'b0, 0);
    do_txn("wrap1", 16'd1, 16'd1, 16'd1, 16'd1, 32'd4, 4'd8, 1'b0, 0);
    do_txn("wrap2", 16'd2, 16'd0, 16'd0, 16'd1, 32'd3, 4'd12, 1'b0, 0);
    do_txn("zero", 16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 4'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_acc_seq.md
# dot_product_acc_seq

Sequential reduction stage that sits directly downstream of the elementwise multiplier. It accepts one 4-element vector of 2N-bit unsigned products per transaction and adds one element per clock into a widened accumulator. It then presents the dot-product sum under a valid/ready handshake. It exposes an activity pulse and a wrapping cycle counter, so the team can compare sequential cost against the multiplier stage.

## Interface
- N, default 8: operand width of the upstream multiplier. Products are 2N bits wide and the sum is 2N+2 bits wide.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  the products vector is valid
- in_ready  output  1  the block can accept a vector
- products  input  [2N-1:0] x [0:3]  unpacked array of unsigned products
- out_valid  output  1  sum is valid
- out_ready  input  1  downstream accepts sum
- sum  output  [2N+1:0]  unsigned dot-product result
- pulse_acc  output  1  high while accumulating
- cycle_count_acc  output  [3:0]  count of accumulate cycles, modulo 16

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ACC: add one element per cycle, idx 0..3.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> ACC on an edge where in_valid && in_ready:
  - all four products are copied into internal registers;
  - accumulator and idx are cleared to 0;
  - in_ready drops to 0.
- ACC, each edge:
  - acc <= acc + zero-extended captured[idx];
  - idx <= idx+1;
  - cycle_count_acc <= cycle_count_acc+1, wrapping 15 -> 0.
- ACC -> DONE on the edge that adds idx 3. sum <= final acc and out_valid <= 1 on that same edge.
- DONE -> IDLE on an edge where out_valid && out_ready. out_valid <= 0 and in_ready <= 1 on that edge.
- DONE does not accept a new vector in the same cycle as the output handshake. in_ready rises one edge later.
- pulse_acc is registered and equals (state == ACC).
- Arithmetic: unsigned with no overflow possible, since 4*(2^N-1)^2 < 2^(2N+2). Products are zero-extended to 2N+2 bits before addition.
- Inputs are ignored outside the IDLE accept edge:
  - in_valid and products may change freely during ACC and DONE;
  - out_ready is ignored outside DONE.
- sum holds its last value until the next DONE entry. It is not cleared on return to IDLE.

## Timing
- Reset values, applied immediately on rst assertion regardless of clk:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, pulse_acc=0, cycle_count_acc=0;
  - internal registers and idx=0.
- Reset mid-ACC or mid-DONE aborts the transaction. No partial sum is ever presented.
- Latency, with the accept at edge E0:
  - pulse_acc is high after E0 through E4;
  - out_valid is high after E4;
  - the minimum transaction length is 6 edges (E0 accept, E1..E4 accumulate, E5 output handshake). The next accept is at E6 at the earliest.
- Backpressure: while out_ready=0 in DONE, sum, out_valid and cycle_count_acc hold steady, and in_ready stays 0.
- Every output is a registered output.

## Test plan
- Basic sum: after reset, drive products={1,2,3,4} with in_valid for one edge, and tie out_ready=1.
  - Required: in_ready=0 for E0..E5.
  - Required: pulse_acc high for 4 cycles.
  - Required: out_valid high for exactly one cycle after E4 with sum=10.
  - Required: cycle_count_acc=4.
- Maximum values (N=8): products={65025,65025,65025,65025}.
  - Required: sum=260100 (0x3F804) with no truncation in the 18-bit output.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises.
  - Required: sum and out_valid are stable and in_ready=0 throughout.
  - Required: the handshake completes on the first edge where out_ready=1, and in_ready=1 on the next cycle.
- Input isolation: after accepting {5,6,7,8}, change products to {100,100,100,100} and toggle in_valid during ACC.
  - Required: sum=26 and only one transaction occurs.
- Reset mid-operation: assert rst asynchronously between E2 and E3.
  - Required: all outputs return to reset values immediately and out_valid never asserts.
  - Required: a subsequent vector {2,2,2,2} yields sum=8 with cycle_count_acc=4.
- Counter wrap and zero vector: run four back-to-back transactions, with the last one being {0,0,0,0}.
  - Required: cycle_count_acc reads 4, 8, 12, 0 after each transaction.
  - Required: the zero vector gives sum=0 with out_valid asserted.
